// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : fifo_uart_tx
// Drains a registered-read FIFO and serialises each word as a UART frame.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_WIDTH + 2);

   localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] c_data_last = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] c_stop_last = IDX_W'(STOP_BITS - 1);
   localparam logic             c_odd       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]      r_idx, w_idx_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
   logic                  r_parity, w_parity_nxt;
   logic                  r_done, w_done_nxt;
   logic                  w_bit_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_shift  <= w_shift_nxt;
         r_parity <= w_parity_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = '0;
      w_idx_nxt    = r_idx;
      w_shift_nxt  = r_shift;
      w_parity_nxt = r_parity;
      w_done_nxt   = 1'b0;
      w_bit_end    = (r_cnt == c_cnt_last);

      // Baud counter only runs while a bit is on the line.
      if (r_state == S_START || r_state == S_DATA ||
          r_state == S_PARITY || r_state == S_STOP) begin
         w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (enable && !fifo_empty) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_shift_nxt  = fifo_data;
            w_parity_nxt = (^fifo_data) ^ c_odd;
            w_state_nxt  = S_START;
         end
         S_START: begin
            if (w_bit_end) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = r_shift >> 1;
               if (r_idx == c_data_last) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // The stop phase reuses the bit index to count stop bits.
            if (w_bit_end) begin
               if (r_idx == c_stop_last) begin
                  w_idx_nxt   = '0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (r_state)
         S_START:  tx = 1'b0;
         S_DATA:   tx = r_shift[0];
         S_PARITY: tx = r_parity;
         default:  tx = 1'b1;
      endcase
   end

   assign fifo_read_en = (r_state == S_FETCH);
   assign busy         = (r_state != S_IDLE);
   assign tx_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_uart_tx
// Self-checking bench: FIFO model plus a bit-time frame reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

   localparam int CPB = 16;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en     [3];
   logic          fempty [3];
   logic [DW-1:0] fdata  [3];
   logic          rd     [3];
   logic          tx_w   [3];
   logic          busy_w [3];
   logic          done_w [3];

   int pen   [3] = '{0, 1, 1};
   int podd  [3] = '{0, 0, 1};
   int nstop [3] = '{1, 1, 2};

   logic [DW-1:0] mem [3][32];
   int wp [3];
   int rp [3];
   int rd_cnt [3];
   int underflow;
   int n_total;
   int n_bad;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                  .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fempty[0]),
      .fifo_data(fdata[0]), .fifo_read_en(rd[0]), .tx(tx_w[0]),
      .busy(busy_w[0]), .tx_done(done_w[0]));

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                  .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fempty[1]),
      .fifo_data(fdata[1]), .fifo_read_en(rd[1]), .tx(tx_w[1]),
      .busy(busy_w[1]), .tx_done(done_w[1]));

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
                  .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(fempty[2]),
      .fifo_data(fdata[2]), .fifo_read_en(rd[2]), .tx(tx_w[2]),
      .busy(busy_w[2]), .tx_done(done_w[2]));

   // Registered-read FIFO: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rd[i] === 1'b1) begin
            rd_cnt[i] <= rd_cnt[i] + 1;
            if (rp[i] == wp[i]) begin
               underflow <= underflow + 1;
            end else begin
               fdata[i] <= mem[i][rp[i] % 32];
               rp[i]    <= rp[i] + 1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) fempty[i] = (rp[i] == wp[i]);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_total++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp_v, $time);
      end
   endtask

   task automatic push(input int i, input logic [DW-1:0] v);
      mem[i][wp[i] % 32] = v;
      wp[i] = wp[i] + 1;
   endtask

   // Line level during bit slot b of a frame carrying word w on instance i.
   function automatic logic exp_bit(input int i, input logic [DW-1:0] w, input int b);
      if (b == 0) return 1'b0;
      if (b <= DW) return w[b-1];
      if (pen[i] != 0 && b == DW + 1) return (^w) ^ (podd[i] != 0);
      return 1'b1;
   endfunction

   // Waits for the start bit, then checks every cycle of the frame and the
   // tx_done pulse. Returns positioned on the tx_done cycle.
   task automatic check_frame(input int i, input logic [DW-1:0] w, input int gap, input int tmo);
      int n = 0;
      int len;
      len = (1 + DW + pen[i] + nstop[i]) * CPB;
      while (tx_w[i] !== 1'b0 && n < tmo) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("done_clear", done_w[i], 1'b0);
      end
      if (tx_w[i] !== 1'b0) begin
         chk("start_timeout", tx_w[i], 1'b0);
         return;
      end
      if (gap >= 0) chk("idle_gap", n, gap);
      for (int k = 0; k < len; k++) begin
         chk("tx_bit", tx_w[i], exp_bit(i, w, k / CPB));
         chk("busy_frame", busy_w[i], 1'b1);
         chk("done_in_frame", done_w[i], 1'b0);
         @(negedge clk);
      end
      chk("tx_done", done_w[i], 1'b1);
      chk("busy_end", busy_w[i], 1'b0);
   endtask

   task automatic idle_check(input int i, input int cycles, input string tag);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         chk({tag, "_tx"}, tx_w[i], 1'b1);
         chk({tag, "_busy"}, busy_w[i], 1'b0);
         chk({tag, "_rd"}, rd[i], 1'b0);
         chk({tag, "_done"}, done_w[i], 1'b0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] w1, w2, w3;
      logic [DW-1:0] rw [4];
      int base;
      for (int i = 0; i < 3; i++) en[i] = 1'b0;
      #1 rst = 1'b0;

      // Reset held with a loaded FIFO and enable high: no activity.
      push(0, 8'hA5);
      en[0] = 1'b1;
      idle_check(0, 20, "reset_hold");
      chk("reset_pops", rd_cnt[0], 0);
      rst = 1'b1;

      // Single default frame.
      check_frame(0, 8'hA5, 3, 10);
      chk("a5_pops", rd_cnt[0], 1);

      // Back-to-back extremes.
      push(0, 8'h00);
      push(0, 8'hFF);
      check_frame(0, 8'h00, 3, 10);
      check_frame(0, 8'hFF, 3, 10);
      chk("b2b_pops", rd_cnt[0], 3);

      // Random back-to-back burst.
      for (int j = 0; j < 4; j++) begin
         rw[j] = DW'($urandom);
         push(0, rw[j]);
      end
      for (int j = 0; j < 4; j++) check_frame(0, rw[j], 3, 10);
      chk("rand_pops", rd_cnt[0], 7);

      // Parity variants, including odd parity with two stop bits.
      en[1] = 1'b1;
      push(1, 8'h07);
      check_frame(1, 8'h07, -1, 10);
      w1 = DW'($urandom);
      push(1, w1);
      check_frame(1, w1, -1, 10);
      en[2] = 1'b1;
      push(2, 8'h07);
      check_frame(2, 8'h07, -1, 10);
      w1 = DW'($urandom);
      push(2, w1);
      check_frame(2, w1, -1, 10);
      chk("parity_pops", rd_cnt[1] + rd_cnt[2], 4);
      en[1] = 1'b0;
      en[2] = 1'b0;

      // Enable dropped mid-frame: frame finishes, then nothing until re-enabled.
      base = rd_cnt[0];
      w1 = DW'($urandom);
      w2 = DW'($urandom);
      w3 = DW'($urandom);
      push(0, w1);
      push(0, w2);
      push(0, w3);
      fork
         check_frame(0, w1, -1, 10);
         begin
            repeat (60) @(negedge clk);
            en[0] = 1'b0;
         end
      join
      idle_check(0, 40, "enable_low");
      chk("enable_low_pops", rd_cnt[0], base + 1);
      en[0] = 1'b1;
      check_frame(0, w2, -1, 10);
      check_frame(0, w3, 3, 10);
      chk("reenable_pops", rd_cnt[0], base + 3);

      // Asynchronous reset during data bit 3.
      base = rd_cnt[0];
      push(0, 8'h3C);
      for (int c = 0; c < 10 && tx_w[0] !== 1'b0; c++) @(negedge clk);
      chk("rst_start_seen", tx_w[0], 1'b0);
      repeat (CPB + 3 * CPB + 8) @(negedge clk);
      chk("pre_reset_busy", busy_w[0], 1'b1);
      rst = 1'b0;
      #1;
      chk("async_tx", tx_w[0], 1'b1);
      chk("async_busy", busy_w[0], 1'b0);
      chk("async_done", done_w[0], 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle_check(0, 40, "post_reset");
      chk("post_reset_pops", rd_cnt[0], base + 1);
      chk("underflow", underflow, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the synchronous FIFO. When enabled and the FIFO is non-empty, it pops one word through the FIFO read port and transmits it as an asynchronous serial (UART-style) frame on a single line. Frames are LSB first, with optional parity. The block sits between the FIFO's read side (read_en/data_out/empty) and the chip-level serial pin.

Parameters:
DATA_WIDTH, 8, word width; must equal the FIFO data width.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal values >= 2.
STOP_BITS, 1, number of stop bits; 1 or 2.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  1 = new frames may be started.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO data_out.
fifo_read_en  output  1  FIFO read_en; one-cycle pulse per popped word.
tx  output  1  serial line; idles high.
busy  output  1  1 whenever state != IDLE.
tx_done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: tx=1, fifo_read_en=0, busy=0, tx_done=0.
  - Internal: state=IDLE, baud counter=0, bit index=0, shift register=0.
  - Release is synchronous to clk; the first possible fetch is evaluated on the first rising edge after release.
- FIFO read contract: the read is registered. fifo_data is valid on the cycle after the cycle in which fifo_read_en=1.
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - If enable=1 and fifo_empty=0 at an edge, go to FETCH.
- FETCH (1 cycle): fifo_read_en=1, only in this state; then go to WAIT.
- WAIT (1 cycle): fifo_data is captured into the shift register at the end of this cycle; then go to START.
- All outputs are registered, or decoded from registered state. tx has no combinational path from inputs.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and clears on every bit transition.
  - Each bit is held on tx for exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit time; then go to DATA.
- DATA:
  - tx = shift register bit 0; shift right once per bit.
  - Bit index runs 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = XOR of the captured data bits, inverted when PARITY_ODD=1; lasts one bit time.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - tx_done=1 for the first IDLE cycle only.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles from the first START cycle to the end of STOP.
- Back-to-back frames: the FIFO stays non-empty and enable=1. Between the end of STOP and the next start bit there are exactly 3 idle-high cycles (IDLE, FETCH, WAIT).
- enable=0 while busy: the current frame completes unchanged. No further FETCH occurs until enable=1.
- enable or fifo_empty changing during FETCH/WAIT: the popped word is transmitted regardless.
- fifo_empty is sampled only in IDLE. The block never pops from an empty FIFO.
- Reset mid-frame: tx returns high immediately and the popped word is discarded. After release the block re-evaluates IDLE.
- Exactly one fifo_read_en pulse and one tx_done pulse per frame.

Test Plan:
1. Hold rst=0 with the FIFO pre-loaded -> tx=1, fifo_read_en=0, busy=0, tx_done=0 throughout; no pops.
2. Defaults, write 0xA5, enable=1 -> one fifo_read_en pulse. tx is low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. tx_done pulses once, 160 cycles after START entry; busy drops with it.
3. Write 0x00 then 0xFF -> exactly two read_en pulses. Exactly 3 high cycles between the first stop-bit end and the second start bit. Data bits are all-0 then all-1.
4. PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit 1, frame 176 cycles. With PARITY_ODD=1 -> parity bit 0. With STOP_BITS=2 -> stop high 32 cycles.
5. FIFO holds 3 words; drop enable during the data bits of word 1 -> word 1 completes, no further read_en while enable=0. Re-assert enable -> words 2 and 3 are sent in order.
6. Assert rst=0 during data bit 3 of 0x3C -> tx=1 asynchronously, busy=0. After release with fifo_empty=1 -> no read_en and tx stays high.
